// File: rtl/mips_defs.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, reset vector
// and the fetch-buffer entry layout.
package mips_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      DRAIN = 2'b10
   } fetch_state_t;

   localparam logic [29:0] RESET_ADDR_DEFAULT = 30'h3000;
   localparam int          ENTRY_WIDTH        = 62;

   function automatic logic [ENTRY_WIDTH-1:0] pack_entry(input logic [29:0] pc,
                                                          input logic [31:0] instr);
      return {pc, instr};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of {pc, instruction} between the fetch unit and decode.
// A flush empties it in one cycle; storage is only cleared by Reset.
module fetch_fifo
   import mips_defs::*;
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [ENTRY_WIDTH-1:0] wr_data,
   output logic [ENTRY_WIDTH-1:0] rd_data,
   output logic                   full,
   output logic                   empty
);

   logic [ENTRY_WIDTH-1:0] mem [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: storage is reset as well so the head reads as zero out of reset.
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// queued in a 2-entry buffer, redirects flush the buffer and drop in-flight data.
module instr_fetch
   import mips_defs::*;
#(
   parameter logic [29:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Redirect,
   input  logic [29:0] RedirectAddr,
   output logic        MemReq,
   output logic [29:0] MemAddr,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [29:0] InstrPC,
   input  logic        InstrReady
);

   fetch_state_t           state;
   logic [29:0]            fa;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [ENTRY_WIDTH-1:0] head;

   // Only the WAIT state keeps returned data; DRAIN means the ack is discarded.
   assign push = (state == WAIT) && MemAck && !Redirect;
   assign pop  = InstrValid && InstrReady && !Redirect;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         fa     <= RESET_ADDR;
         MemReq <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
         case (state)
            IDLE: begin
               if (Redirect)
                  fa <= RedirectAddr;
               else if (!full) begin
                  MemReq <= 1'b1;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (Redirect) begin
                  fa     <= RedirectAddr;
                  MemReq <= 1'b0;
                  state  <= MemAck ? IDLE : DRAIN;
               end else if (MemAck) begin
                  fa     <= fa + 30'd1;
                  MemReq <= 1'b0;
                  state  <= IDLE;
               end
            end
            DRAIN: begin
               if (Redirect)
                  fa <= RedirectAddr;
               if (MemAck)
                  state <= IDLE;
            end
            default: begin
               MemReq <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign MemAddr = fa;

   fetch_fifo u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .flush   (Redirect),
      .push    (push),
      .pop     (pop),
      .wr_data (pack_entry(MemAddr, MemRData)),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign InstrValid       = !empty;
   assign {InstrPC, Instr} = head;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory responder plus a program-order
// model of which fetched words decode should see, and from which addresses.
module tb_instr_fetch;

   localparam logic [29:0] RST_ADDR = 30'h3000;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Redirect;
   logic [29:0] RedirectAddr;
   logic        MemReq;
   logic [29:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [29:0] InstrPC;
   logic        InstrReady;

   always #5 Clk = ~Clk;

   instr_fetch #(.RESET_ADDR(RST_ADDR)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Redirect     (Redirect),
      .RedirectAddr (RedirectAddr),
      .MemReq       (MemReq),
      .MemAddr      (MemAddr),
      .MemAck       (MemAck),
      .MemRData     (MemRData),
      .InstrValid   (InstrValid),
      .Instr        (Instr),
      .InstrPC      (InstrPC),
      .InstrReady   (InstrReady)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {a, 2'b11} ^ 32'h5A5A_C3C3;
   endfunction

   // Model: words decode should see, in order, plus the memory's view of the request.
   logic [29:0] q_pc[$];
   logic [29:0] pops[$];
   logic [29:0] issue_log[$];
   bit          pending     = 0;
   bit          pend_kept   = 0;
   bit          just_issued = 0;
   bit          last_reset  = 0;
   logic [29:0] pend_addr   = '0;
   logic [29:0] issue_ptr   = RST_ADDR;
   int          timer       = 0;
   int          idle_cnt    = 0;
   int          dly_min     = 0;
   int          dly_max     = 0;
   int          ready_pct   = 100;
   int          redir_pct   = 0;
   logic [29:0] slow_addr   = '0;
   int          slow_dly    = -1;

   task automatic observe();
      just_issued = 0;
      if (last_reset) begin
         check("rst_memreq", MemReq, 1'b0);
         check("rst_valid", InstrValid, 1'b0);
         check("rst_instr", Instr, 32'h0);
         check("rst_pc", InstrPC, 30'h0);
      end
      check("instr_valid", InstrValid, q_pc.size() > 0);
      if (q_pc.size() > 0) begin
         check("head_pc", InstrPC, q_pc[0]);
         check("head_instr", Instr, mem_word(q_pc[0]));
      end
      if (pending) begin
         if (pend_kept) begin
            check("req_hold", MemReq, 1'b1);
            check("addr_hold", MemAddr, pend_addr);
         end else
            check("drain_req", MemReq, 1'b0);
      end else if (MemReq === 1'b1) begin
         check("issue_addr", MemAddr, issue_ptr);
         check("issue_room", q_pc.size() < 2, 1'b1);
         pending     = 1;
         pend_kept   = 1;
         pend_addr   = MemAddr;
         just_issued = 1;
         issue_log.push_back(MemAddr);
         if (slow_dly >= 0 && MemAddr == slow_addr)
            timer = slow_dly;
         else
            timer = int'($urandom_range(dly_max, dly_min));
      end
      if (!pending && !last_reset && q_pc.size() < 2) begin
         idle_cnt++;
         check("stall_bound", idle_cnt <= 4, 1'b1);
      end else
         idle_cnt = 0;
   endtask

   task automatic drive_step(input bit f_redir, input logic [29:0] f_tgt, input bit f_rst);
      bit          ack;
      bit          redir;
      bit          rdy;
      logic [29:0] tgt;
      ack   = pending && timer == 0;
      redir = !f_rst && (f_redir || $urandom_range(99) < redir_pct);
      tgt   = f_redir ? f_tgt : (($urandom_range(3) == 0) ? 30'h3FFF_FFFE : 30'($urandom));
      rdy   = $urandom_range(99) < ready_pct;
      Reset        = f_rst;
      Redirect     = redir;
      RedirectAddr = tgt;
      MemAck       = ack;
      MemRData     = ack ? mem_word(pend_addr) : $urandom;
      InstrReady   = rdy;
      if (f_rst) begin
         q_pc.delete();
         issue_ptr = RST_ADDR;
         pend_kept = 0;
      end else if (redir) begin
         q_pc.delete();
         issue_ptr = tgt;
         pend_kept = 0;
         idle_cnt  = 0;
      end else begin
         if (rdy && q_pc.size() > 0)
            pops.push_back(q_pc.pop_front());
         if (ack && pend_kept) begin
            q_pc.push_back(pend_addr);
            issue_ptr = issue_ptr + 30'd1;
         end
      end
      if (ack)
         pending = 0;
      else if (pending)
         timer--;
      last_reset = f_rst;
      @(posedge Clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         observe();
         drive_step(1'b0, 30'h0, 1'b0);
      end
   endtask

   // Holds Reset until any in-flight read has been answered, so its ack lands inside reset.
   task automatic reset_seq();
      drive_step(1'b0, 30'h0, 1'b1);
      for (int g = 0; g < 20 && pending; g++) begin
         observe();
         drive_step(1'b0, 30'h0, 1'b1);
      end
      observe();
      drive_step(1'b0, 30'h0, 1'b1);
   endtask

   // Returns just after observing the matching new request, before driving that cycle.
   task automatic wait_issue(input logic [29:0] addr, input bit any, input string tag);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         observe();
         if (just_issued && (any || pend_addr == addr))
            found = 1;
         else
            drive_step(1'b0, 30'h0, 1'b0);
      end
      check(tag, found, 1'b1);
   endtask

   function automatic logic [63:0] first_issue();
      return (issue_log.size() > 0) ? 64'(issue_log[0]) : 64'hDEAD_BEEF;
   endfunction

   initial begin
      Reset = 1'b1; Redirect = 1'b0; RedirectAddr = '0;
      MemAck = 1'b0; MemRData = '0; InstrReady = 1'b0;
      @(posedge Clk);
      #1;
      reset_seq();

      // Streaming with single-cycle memory and an always-ready decoder.
      issue_log.delete();
      pops.delete();
      run(12);
      check("a_issue_count", issue_log.size() >= 3, 1'b1);
      check("a_pop_count", pops.size() >= 3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i < issue_log.size()) check("a_issue_addr", issue_log[i], RST_ADDR + 30'(i));
         if (i < pops.size())      check("a_pop_pc", pops[i], RST_ADDR + 30'(i));
      end

      // Decoder stalled: buffer fills to two and fetching stops.
      ready_pct = 0;
      run(8);
      observe();
      check("b_memreq_low", MemReq, 1'b0);
      check("b_valid", InstrValid, 1'b1);
      drive_step(1'b0, 30'h0, 1'b0);
      run(3);
      ready_pct = 100;
      run(4);

      // Redirect while the read for 0x3003 is outstanding; its late ack is dropped.
      observe();
      reset_seq();
      slow_addr = 30'h3003;
      slow_dly  = 3;
      wait_issue(30'h3003, 1'b0, "c_wait_issue");
      drive_step(1'b1, 30'h0040, 1'b0);
      check("c_flush_valid", InstrValid, 1'b0);
      check("c_drain_req", MemReq, 1'b0);
      issue_log.delete();
      slow_dly = -1;
      run(10);
      check("c_next_addr", first_issue(), 64'h40);

      // Redirect in the same cycle as the ack.
      wait_issue(30'h0, 1'b1, "d_wait_issue");
      drive_step(1'b1, 30'h1234, 1'b0);
      check("d_no_push", InstrValid, 1'b0);
      check("d_req_low", MemReq, 1'b0);
      issue_log.delete();
      run(6);
      check("d_next_addr", first_issue(), 64'h1234);

      // Address wrap at the top of the 30-bit space.
      observe();
      pops.delete();
      drive_step(1'b1, 30'h3FFF_FFFF, 1'b0);
      run(10);
      check("e_pop_count", pops.size() >= 2, 1'b1);
      if (pops.size() >= 2) begin
         check("e_pop_top", pops[0], 30'h3FFF_FFFF);
         check("e_pop_wrap", pops[1], 30'h0);
      end

      // Reset during a slow read; the late ack must not reach the buffer.
      dly_min = 5;
      dly_max = 5;
      wait_issue(30'h0, 1'b1, "f_wait_issue");
      reset_seq();
      dly_min = 0;
      dly_max = 0;
      issue_log.delete();
      run(6);
      check("f_next_addr", first_issue(), 64'(RST_ADDR));

      // Random mix of latencies, back-pressure, redirects and occasional resets.
      dly_min   = 0;
      dly_max   = 3;
      ready_pct = 60;
      redir_pct = 5;
      for (int i = 0; i < 3000; i++) begin
         observe();
         if ($urandom_range(249) == 0)
            reset_seq();
         else
            drive_step(1'b0, 30'h0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 30'h3000, the word address [31:2] of the first fetch after reset.
REQ-002 SHALL have port Clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port Redirect  input  1  branch/jump taken; restart fetch at RedirectAddr.
REQ-005 SHALL have port RedirectAddr  input  30  new word address [31:2].
REQ-006 SHALL have port MemReq  output  1  instruction-memory read request.
REQ-007 SHALL have port MemAddr  output  30  word address [31:2] of the request.
REQ-008 SHALL have port MemAck  input  1  read complete; MemRData valid this cycle.
REQ-009 SHALL have port MemRData  input  32  instruction word.
REQ-010 SHALL have port InstrValid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port Instr  output  32  head instruction.
REQ-012 SHALL have port InstrPC  output  30  word address [31:2] of the head instruction.
REQ-013 SHALL have port InstrReady  input  1  decode accepts the head; pop when InstrValid and InstrReady are both high.

Function
REQ-014 SHALL keep a fetch pointer FA; each issued request uses MemAddr=FA, and FA increments by 1 (30-bit, 30'h3FFFFFFF wraps to 0) on the MemAck for that request.
REQ-015 SHALL allow at most one outstanding request; MemReq and MemAddr SHALL stay stable from assertion until the cycle MemAck is sampled high.
REQ-016 SHALL buffer instructions in a 2-entry FIFO of {InstrPC, Instr}; a new request SHALL issue only when occupancy plus outstanding requests is below 2.
REQ-017 SHALL push {MemAddr, MemRData} on MemAck, unless the request is marked discard; the pushed entry is visible on InstrValid the next cycle (one-cycle latency from ack).
REQ-018 SHALL allow push and pop in the same cycle; occupancy is unchanged.
REQ-019 SHALL use a state machine: IDLE (no request outstanding), WAIT (request outstanding, data kept), DRAIN (request outstanding, data discarded).
REQ-020 SHALL use these transitions: IDLE->WAIT on issue; WAIT->IDLE on MemAck; WAIT->DRAIN on Redirect without MemAck; DRAIN->IDLE on MemAck.
REQ-021 SHALL, on Redirect, flush the FIFO (InstrValid low the next cycle) and set FA=RedirectAddr, whatever the state of InstrReady.
REQ-022 SHALL, on Redirect in the same cycle as MemAck, discard that data and go to IDLE.
REQ-023 SHALL keep MemReq low in DRAIN and after a Redirect until the pointer update has taken effect; the first request after a redirect SHALL issue no earlier than the cycle after IDLE is entered.
REQ-024 SHALL apply a second Redirect that arrives while in DRAIN by overwriting FA; the state stays DRAIN.
REQ-025 SHALL hold Instr and InstrPC stable while InstrValid is high and InstrReady is low.

Reset
REQ-026 SHALL, on Reset, set FA=RESET_ADDR, state=IDLE, FIFO empty, MemReq=0, InstrValid=0, Instr=0, InstrPC=0, discard flag=0.
REQ-027 SHALL ignore any MemAck for a request that was outstanding when Reset was asserted; Reset has priority over Redirect and MemAck.

Structure
REQ-028 SHALL place the state encodings (IDLE/WAIT/DRAIN) and RESET_ADDR default in the shared mips_defs package.
REQ-029 SHALL implement the 2-entry buffer as sub-module fetch_fifo (62-bit wide, push/pop/full/empty).

Verification
REQ-030 Reset, then MemAck one cycle after each MemReq, InstrReady=1 -> MemAddr 30'h3000, 30'h3001, 30'h3002; InstrPC follows in order with the data returned.
REQ-031 InstrReady=0, memory acks immediately -> exactly 2 entries buffered, MemReq stays low, and the head is held stable until InstrReady rises.
REQ-032 Redirect to 30'h0040 while the request for 30'h3003 is waiting, MemAck 3 cycles later -> that data is dropped, InstrValid=0, and the next MemAddr is 30'h0040.
REQ-033 Redirect in the same cycle as MemAck -> no push, state IDLE, and the next request is for RedirectAddr.
REQ-034 Redirect to 30'h3FFFFFFF, two acks -> InstrPC 30'h3FFFFFFF then 30'h00000000.
REQ-035 Reset asserted mid-WAIT with a late MemAck -> no push, and the next MemAddr is 30'h3000.
